// File: rtl/ose_quad_pkg.sv
// ose_quad_pkg: shared types for the quadrature decoder.
//   qstate_t  : Gray-coded {a,b} phase state. Up order is S00->S10->S11->S01.
//   MODE_*    : resolution select encodings for the 'mode' port.
//   q_next_up : successor of a state in the up direction.
package ose_quad_pkg;

  typedef enum logic [1:0] {
    S00 = 2'b00,
    S01 = 2'b01,
    S10 = 2'b10,
    S11 = 2'b11
  } qstate_t;

  localparam logic [1:0] MODE_X1  = 2'b00;
  localparam logic [1:0] MODE_X2  = 2'b01;
  localparam logic [1:0] MODE_X4  = 2'b10;
  localparam logic [1:0] MODE_X4B = 2'b11;

  function automatic qstate_t q_next_up(input qstate_t s);
    case (s)
      S00:     return S10;
      S10:     return S11;
      S11:     return S01;
      default: return S00;
    endcase
  endfunction

endpackage

// File: rtl/ose_quad_chan.sv
// ose_quad_chan: one quadrature channel (synchroniser, glitch filter,
// Gray-state FSM, position counter).
// Ports: clk, rst (sync, active high), a/b (async phase inputs),
//   mode (resolution), clr (sync clear of pos/err), step/up/dirch/pos/err.
// Build option: OSE_QUAD_ERR_EN enables the sticky illegal-transition flag.
module ose_quad_chan
  import ose_quad_pkg::*;
#(
  parameter int CNT_W    = 16,
  parameter int FILT_LEN = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             a,
  input  logic             b,
  input  logic [1:0]       mode,
  input  logic             clr,
  output logic             step,
  output logic             up,
  output logic             dirch,
  output logic [CNT_W-1:0] pos,
  output logic             err
);

  localparam logic [7:0]       FMAX = 8'(FILT_LEN - 1);
  localparam logic [CNT_W-1:0] ONE  = CNT_W'(1);

  logic [1:0]      s1, s2, acc;
  logic [1:0][7:0] fcnt;

  // Each bit filtered separately: accept only after FILT_LEN consecutive
  // cycles of disagreement; any agreement restarts the count.
  always_ff @(posedge clk) begin
    if (rst) begin
      s1   <= '0;
      s2   <= '0;
      acc  <= '0;
      fcnt <= '0;
    end else begin
      s1 <= {a, b};
      s2 <= s1;
      for (int i = 0; i < 2; i++) begin
        if (s2[i] != acc[i]) begin
          if (fcnt[i] == FMAX) begin
            acc[i]  <= s2[i];
            fcnt[i] <= '0;
          end else begin
            fcnt[i] <= fcnt[i] + 8'd1;
          end
        end else begin
          fcnt[i] <= '0;
        end
      end
    end
  end

  // FSM state follows the accepted pair one cycle later; the transition
  // (state_q -> state_d) decides counting.
  qstate_t state_q, state_d;
  logic    is_up, is_dn, cnt;

  always_ff @(posedge clk) begin
    if (rst) state_q <= S00;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = qstate_t'(acc);
    is_up   = (state_d == q_next_up(state_q));
    is_dn   = (state_q == q_next_up(state_d));
    cnt     = 1'b0;
    case (mode)
      MODE_X1: cnt = (is_up && state_q == S01) || (is_dn && state_q == S00);
      MODE_X2: cnt = (is_up || is_dn) && (state_q[1] != state_d[1]);
      default: cnt = is_up || is_dn;
    endcase
  end

  // 'have' marks that a step was counted since reset/clr, so the first
  // step never reports a direction change.
  logic have;

  always_ff @(posedge clk) begin
    if (rst) begin
      step  <= 1'b0;
      dirch <= 1'b0;
      up    <= 1'b1;
      pos   <= '0;
      have  <= 1'b0;
    end else begin
      step  <= 1'b0;
      dirch <= 1'b0;
      if (clr) begin
        pos  <= '0;
        have <= 1'b0;
      end else if (cnt) begin
        step  <= 1'b1;
        up    <= is_up;
        dirch <= have && (is_up != up);
        have  <= 1'b1;
        pos   <= is_up ? pos + ONE : pos - ONE;
      end
    end
  end

`ifdef OSE_QUAD_ERR_EN
  logic dbl, err_q;
  assign dbl = (state_q[1] != state_d[1]) && (state_q[0] != state_d[0]);

  always_ff @(posedge clk) begin
    if (rst || clr) err_q <= 1'b0;
    else if (dbl)   err_q <= 1'b1;
  end
  assign err = err_q;
`else
  // Double changes simply resync the FSM (state_d) without counting.
  assign err = 1'b0;
`endif

endmodule

// File: rtl/ose_quad_decoder.sv
// ose_quad_decoder: NCH independent quadrature decoders.
// Ports: clk, rst (sync, active high), a/b[NCH] phase inputs, mode
//   (00=x1, 01=x2, 1x=x4), clr[NCH], step/up/dirch/err[NCH],
//   pos[NCH*CNT_W] with channel i at [i*CNT_W +: CNT_W].
// Build option: OSE_QUAD_ERR_EN enables the sticky err flag per channel.
module ose_quad_decoder
  import ose_quad_pkg::*;
#(
  parameter int NCH      = 2,
  parameter int CNT_W    = 16,
  parameter int FILT_LEN = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [NCH-1:0]       a,
  input  logic [NCH-1:0]       b,
  input  logic [1:0]           mode,
  input  logic [NCH-1:0]       clr,
  output logic [NCH-1:0]       step,
  output logic [NCH-1:0]       up,
  output logic [NCH-1:0]       dirch,
  output logic [NCH*CNT_W-1:0] pos,
  output logic [NCH-1:0]       err
);

  for (genvar i = 0; i < NCH; i++) begin : g_ch
    ose_quad_chan #(
      .CNT_W   (CNT_W),
      .FILT_LEN(FILT_LEN)
    ) u_chan (
      .clk  (clk),
      .rst  (rst),
      .a    (a[i]),
      .b    (b[i]),
      .mode (mode),
      .clr  (clr[i]),
      .step (step[i]),
      .up   (up[i]),
      .dirch(dirch[i]),
      .pos  (pos[i*CNT_W +: CNT_W]),
      .err  (err[i])
    );
  end

endmodule

// File: tb/tb_ose_quad_decoder.sv
module tb_ose_quad_decoder;
  localparam int NCH = 2, CNT_W = 4, FILT_LEN = 4;

  logic       clk = 1'b0, rst = 1'b1;
  logic [1:0] a = '0, b = '0, mode = 2'b10, clr = '0;
  logic [1:0] step, up, dirch, err;
  logic [7:0] pos;
  int errors = 0, checks = 0;
  int nstep0 = 0, ndir0 = 0;

  ose_quad_decoder #(.NCH(NCH), .CNT_W(CNT_W), .FILT_LEN(FILT_LEN)) dut (
    .clk(clk), .rst(rst), .a(a), .b(b), .mode(mode), .clr(clr),
    .step(step), .up(up), .dirch(dirch), .pos(pos), .err(err));

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (step[0])  nstep0 <= nstep0 + 1;
    if (dirch[0]) ndir0  <= ndir0 + 1;
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic move(input logic [1:0] na, input logic [1:0] nb);
    a = na; b = nb;
    tick(8);
  endtask

  task automatic test_reset;
    rst = 1'b1; tick(2);
    checks++; if (pos !== 8'h00) begin errors++; $display("FAIL reset_pos got=%h exp=00", pos); end
    checks++; if (step !== 2'b00 || dirch !== 2'b00) begin errors++; $display("FAIL reset_step got=%b/%b exp=00/00", step, dirch); end
    checks++; if (up !== 2'b11 || err !== 2'b00) begin errors++; $display("FAIL reset_up_err got=%b/%b exp=11/00", up, err); end
    rst = 1'b0; tick(2);
  endtask

  task automatic test_x4_up;
    int s0, d0;
    s0 = nstep0; d0 = ndir0;
    mode = 2'b10;
    a = 2'b01; b = 2'b00;
    tick(6);
    checks++; if (step[0] !== 1'b0) begin errors++; $display("FAIL x4_early_step got=%b exp=0", step[0]); end
    tick(1);
    checks++; if (step[0] !== 1'b1 || pos[3:0] !== 4'd1) begin errors++; $display("FAIL x4_first_step got=%b pos=%0d exp=1 pos=1", step[0], pos[3:0]); end
    tick(1);
    move(2'b01, 2'b01);
    move(2'b00, 2'b01);
    move(2'b00, 2'b00);
    checks++; if (pos[3:0] !== 4'd4) begin errors++; $display("FAIL x4_pos got=%0d exp=4", pos[3:0]); end
    checks++; if (nstep0 - s0 !== 4) begin errors++; $display("FAIL x4_steps got=%0d exp=4", nstep0 - s0); end
    checks++; if (up[0] !== 1'b1 || ndir0 - d0 !== 0) begin errors++; $display("FAIL x4_dir got up=%b dirch=%0d exp up=1 dirch=0", up[0], ndir0 - d0); end
  endtask

  task automatic test_x1;
    int s0, d0;
    clr = 2'b01; tick(1); clr = 2'b00;
    checks++; if (pos[3:0] !== 4'd0) begin errors++; $display("FAIL x1_clr got=%0d exp=0", pos[3:0]); end
    mode = 2'b00;
    s0 = nstep0; d0 = ndir0;
    for (int c = 0; c < 2; c++) begin
      move(2'b01, 2'b00); move(2'b01, 2'b01); move(2'b00, 2'b01); move(2'b00, 2'b00);
    end
    checks++; if (pos[3:0] !== 4'd2) begin errors++; $display("FAIL x1_up_pos got=%0d exp=2", pos[3:0]); end
    move(2'b00, 2'b01); move(2'b01, 2'b01); move(2'b01, 2'b00); move(2'b00, 2'b00);
    checks++; if (pos[3:0] !== 4'd1) begin errors++; $display("FAIL x1_dn_pos got=%0d exp=1", pos[3:0]); end
    checks++; if (nstep0 - s0 !== 3) begin errors++; $display("FAIL x1_steps got=%0d exp=3", nstep0 - s0); end
    checks++; if (ndir0 - d0 !== 1 || up[0] !== 1'b0) begin errors++; $display("FAIL x1_dirch got=%0d up=%b exp=1 up=0", ndir0 - d0, up[0]); end
  endtask

  task automatic test_wrap;
    int d0;
    clr = 2'b01; tick(1); clr = 2'b00;
    mode = 2'b10;
    d0 = ndir0;
    move(2'b00, 2'b01);
    checks++; if (pos[3:0] !== 4'd15) begin errors++; $display("FAIL wrap_down got=%0d exp=15", pos[3:0]); end
    checks++; if (ndir0 - d0 !== 0) begin errors++; $display("FAIL wrap_first_dirch got=%0d exp=0", ndir0 - d0); end
    move(2'b00, 2'b00);
    checks++; if (pos[3:0] !== 4'd0) begin errors++; $display("FAIL wrap_up got=%0d exp=0", pos[3:0]); end
    checks++; if (ndir0 - d0 !== 1) begin errors++; $display("FAIL wrap_dirch got=%0d exp=1", ndir0 - d0); end
  endtask

  task automatic test_glitch;
    int s0;
    s0 = nstep0;
    a = 2'b01; tick(3); a = 2'b00; tick(10);
    checks++; if (nstep0 - s0 !== 0 || pos[3:0] !== 4'd0) begin errors++; $display("FAIL glitch3 got steps=%0d pos=%0d exp 0/0", nstep0 - s0, pos[3:0]); end
    a = 2'b01; tick(4); a = 2'b00; tick(3);
    checks++; if (pos[3:0] !== 4'd1) begin errors++; $display("FAIL glitch4_accept got=%0d exp=1", pos[3:0]); end
    tick(8);
    checks++; if (pos[3:0] !== 4'd0 || nstep0 - s0 !== 2) begin errors++; $display("FAIL glitch4_return got pos=%0d steps=%0d exp 0/2", pos[3:0], nstep0 - s0); end
  endtask

  task automatic test_double;
    int s0;
    s0 = nstep0;
    move(2'b01, 2'b01);
`ifdef OSE_QUAD_ERR_EN
    checks++; if (err[0] !== 1'b1) begin errors++; $display("FAIL dbl_err got=%b exp=1", err[0]); end
`else
    checks++; if (err[0] !== 1'b0) begin errors++; $display("FAIL dbl_err got=%b exp=0", err[0]); end
`endif
    checks++; if (pos[3:0] !== 4'd0 || nstep0 - s0 !== 0) begin errors++; $display("FAIL dbl_nocount got pos=%0d steps=%0d exp 0/0", pos[3:0], nstep0 - s0); end
    clr = 2'b01; tick(1); clr = 2'b00;
    checks++; if (err[0] !== 1'b0 || pos[3:0] !== 4'd0) begin errors++; $display("FAIL dbl_clr got err=%b pos=%0d exp 0/0", err[0], pos[3:0]); end
    move(2'b00, 2'b01);
    move(2'b00, 2'b00);
    checks++; if (pos[3:0] !== 4'd2) begin errors++; $display("FAIL dbl_resync got=%0d exp=2", pos[3:0]); end
  endtask

  task automatic test_clr_collide;
    a = 2'b01; b = 2'b00;
    tick(6);
    clr = 2'b01; tick(1); clr = 2'b00;
    checks++; if (pos[3:0] !== 4'd0 || step[0] !== 1'b0 || dirch[0] !== 1'b0) begin errors++; $display("FAIL clr_collide got pos=%0d step=%b dirch=%b exp 0/0/0", pos[3:0], step[0], dirch[0]); end
    tick(2);
    move(2'b01, 2'b01);
    checks++; if (pos[3:0] !== 4'd1) begin errors++; $display("FAIL clr_track got=%0d exp=1", pos[3:0]); end
  endtask

  task automatic test_rst_mid;
    a = 2'b00; b = 2'b01;
    tick(6);
    rst = 1'b1; a = 2'b00; b = 2'b00;
    tick(1);
    checks++; if (pos !== 8'h00 || step !== 2'b00 || dirch !== 2'b00) begin errors++; $display("FAIL rst_mid got pos=%h step=%b dirch=%b exp 00/00/00", pos, step, dirch); end
    checks++; if (up !== 2'b11 || err !== 2'b00) begin errors++; $display("FAIL rst_mid_up got up=%b err=%b exp 11/00", up, err); end
    rst = 1'b0; tick(10);
  endtask

  task automatic test_indep;
    mode = 2'b10;
    a = 2'b11; b = 2'b00;
    tick(6);
    checks++; if (step !== 2'b00) begin errors++; $display("FAIL indep_early got=%b exp=00", step); end
    tick(1);
    checks++; if (step !== 2'b11 || pos !== 8'h11) begin errors++; $display("FAIL indep_step got step=%b pos=%h exp 11/11", step, pos); end
    tick(1);
  endtask

  task automatic test_mode;
    mode = 2'b01;
    move(2'b11, 2'b11);
    checks++; if (pos !== 8'h11) begin errors++; $display("FAIL x2_bchange got=%h exp=11", pos); end
    move(2'b00, 2'b11);
    checks++; if (pos !== 8'h22) begin errors++; $display("FAIL x2_achange got=%h exp=22", pos); end
    mode = 2'b00;
    move(2'b00, 2'b00);
    checks++; if (pos !== 8'h33) begin errors++; $display("FAIL mode_switch_x1 got=%h exp=33", pos); end
  endtask

  initial begin
    test_reset;
    test_x4_up;
    test_x1;
    test_wrap;
    test_glitch;
    test_double;
    test_clr_collide;
    test_rst_mid;
    test_indep;
    test_mode;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
